// File: rtl/volcado_pkg.sv
// Shared constants for the register-bank dump controller.
// State encoding, default widths and the checksum beat address.
package volcado_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LEER   = 2'd1;
  localparam logic [1:0] ST_ESPERA = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam int DIR_CHK = 0;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LEER   = ST_LEER,
    S_ESPERA = ST_ESPERA,
    S_FIN    = ST_FIN
  } estado_t;

endpackage

// File: rtl/volcado_registros.sv
// Walks a register range on bank port A and streams each word with its address.
// VOLCADO_CHECKSUM_EN appends a wrap-around sum beat after the register beats.
module volcado_registros
  import volcado_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] dir_ini,
  input  logic [AW-1:0] dir_fin,
  output logic [AW-1:0] dir_a,
  output logic          reg_rd,
  input  logic [DW-1:0] doa,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  estado_t       estado_q, estado_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] fin_q, fin_d;
  logic [AW-1:0] dir_a_q, dir_a_d;
  logic          reg_rd_q, reg_rd_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_dir_q, out_dir_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef VOLCADO_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
  logic          ult_q, ult_d;
`endif

  logic          es_ult;
  logic          hs;

  assign es_ult = (idx_q == fin_q);
  assign hs     = out_valid_q & out_ready;

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    fin_d       = fin_q;
    dir_a_d     = dir_a_q;
    reg_rd_d    = 1'b0;
    out_data_d  = out_data_q;
    out_dir_d   = out_dir_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef VOLCADO_CHECKSUM_EN
    sum_d       = sum_q;
    ult_d       = ult_q;
`endif
    unique case (estado_q)
      S_IDLE: begin
        if (start) begin
          idx_d    = dir_ini;
          fin_d    = dir_fin;
          dir_a_d  = dir_ini;
          reg_rd_d = 1'b1;
          busy_d   = 1'b1;
          estado_d = S_LEER;
`ifdef VOLCADO_CHECKSUM_EN
          sum_d    = '0;
          ult_d    = 1'b0;
`endif
        end
      end
      S_LEER: begin
        out_data_d  = doa;
        out_dir_d   = idx_q;
        out_valid_d = 1'b1;
        estado_d    = S_ESPERA;
`ifdef VOLCADO_CHECKSUM_EN
        // last register beat is no longer the final beat
        out_last_d  = 1'b0;
        ult_d       = es_ult;
        sum_d       = sum_q + doa;
`else
        out_last_d  = es_ult;
`endif
      end
      S_ESPERA: begin
        if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            estado_d    = S_FIN;
`ifdef VOLCADO_CHECKSUM_EN
          end else if (ult_q) begin
            out_data_d  = sum_q;
            out_dir_d   = AW'(DIR_CHK);
            out_last_d  = 1'b1;
            ult_d       = 1'b0;
`endif
          end else begin
            out_valid_d = 1'b0;
            idx_d       = idx_q + 1'b1;
            dir_a_d     = idx_q + 1'b1;
            reg_rd_d    = 1'b1;
            estado_d    = S_LEER;
          end
        end
      end
      S_FIN: begin
        busy_d   = 1'b0;
        estado_d = S_IDLE;
      end
      default: begin
        estado_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= S_IDLE;
      idx_q       <= '0;
      fin_q       <= '0;
      dir_a_q     <= '0;
      reg_rd_q    <= 1'b0;
      out_data_q  <= '0;
      out_dir_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef VOLCADO_CHECKSUM_EN
      sum_q       <= '0;
      ult_q       <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      fin_q       <= fin_d;
      dir_a_q     <= dir_a_d;
      reg_rd_q    <= reg_rd_d;
      out_data_q  <= out_data_d;
      out_dir_q   <= out_dir_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef VOLCADO_CHECKSUM_EN
      sum_q       <= sum_d;
      ult_q       <= ult_d;
`endif
    end
  end

  assign dir_a     = dir_a_q;
  assign reg_rd    = reg_rd_q;
  assign out_data  = out_data_q;
  assign out_dir   = out_dir_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/volcado_registros.md
# volcado_registros

Debug read-out controller for the 32×32 register bank. On a start pulse it walks a programmable address range and drives the bank's `dir_a`/`reg_rd` read port. It captures each `doa` word and streams it, tagged with its address, over a valid/ready interface to the debug/UART path. It is a read initiator on the bank's port A and never touches the write port.

## Interface
Parameters:
- `DW`, 32, data width; must match the bank.
- `AW`, 5, register address width.

Ports:
- `clk`  in  1  system clock; the bank reads on negedge, this block acts on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a dump; sampled only in IDLE.
- `dir_ini`  in  AW  first register to dump; sampled at start.
- `dir_fin`  in  AW  last register to dump, inclusive; sampled at start.
- `dir_a`  out  AW  bank port-A address.
- `reg_rd`  out  1  bank read enable.
- `doa`  in  DW  bank port-A data.
- `out_data`  out  DW  streamed word.
- `out_dir`  out  AW  address of `out_data`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_last`  out  1  final beat of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- States:
  - IDLE: wait for `start`.
  - LEER: issue the read.
  - ESPERA: hold the beat until the sink accepts it.
  - FIN: pulse `done`.
- IDLE → LEER on `start`. Latch `idx`=`dir_ini` and `fin`=`dir_fin`.
- LEER, one cycle:
  - `reg_rd`=1 and `dir_a`=`idx`.
  - At the next posedge, capture `doa` into `out_data` and `idx` into `out_dir`.
  - Set `out_valid`=1, set `out_last`=(`idx`==`fin`), and go to ESPERA.
- ESPERA: `reg_rd`=0.
  - On `out_valid && out_ready`, if `out_last`: drop `out_valid` and go to FIN.
  - Otherwise: drop `out_valid`, set `idx`=`idx`+1 (mod 32), and go to LEER.
- FIN: `done`=1 for one cycle, then IDLE.
- Address arithmetic is AW-bit and wraps. If `dir_ini` > `dir_fin`, the dump walks through 31 to 0, e.g. 30,31,0,1. If `dir_ini` == `dir_fin`, the dump is exactly one beat. A full 0..31 dump is 32 beats.
- `start` is ignored while `busy`.
- `dir_a` holds `idx` outside LEER. `reg_rd` is high only in LEER.
- While `out_valid` && !`out_ready`, `out_data`, `out_dir` and `out_last` are stable.

## Timing
- Reset values: state IDLE; `dir_a`=0, `reg_rd`=0, `out_data`=0, `out_dir`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0. Internal `idx`/`fin` are also 0.
- Reset mid-dump clears everything immediately (asynchronous). An in-flight beat is lost. The next `start` restarts from the new `dir_ini`.
- `start` at posedge T0: LEER is active during cycle T0..T1. The bank updates `doa` at the negedge inside that cycle. `out_valid` rises at T1.
- Read latency is 1 cycle. Best-case throughput, with `out_ready` tied high, is one beat per 2 cycles.
- Handshake at posedge Tk on the last beat: `done`=1 during Tk..Tk+1, `busy` falls at Tk+1.
- No combinational path from `out_ready` to any output.

## Configuration
- `VOLCADO_CHECKSUM_EN` defined:
  - A DW-bit wrap-around sum of all dumped words is accumulated.
  - After the last register beat (which then has `out_last`=0), one extra beat follows with `out_data`=sum, `out_dir`=0 and `out_last`=1.
  - The accumulator clears on `start` and on `rst`.
- Not defined: no accumulator, no extra beat, and `out_last` marks the last register beat.

## Structure
- Shared package `volcado_pkg` holds:
  - state encoding localparams ST_IDLE, ST_LEER, ST_ESPERA, ST_FIN;
  - AW/DW defaults;
  - the checksum beat address constant (0).
- Single module; no sub-module is needed. The checksum adder stays inline under the macro.

## Test plan
- Bank preset (r4=18, r5=7, r10=7, r15=0x400000), `dir_ini`=4, `dir_fin`=5, `out_ready`=1: expect beats (4,18), then (5,7) with `out_last`; `done` one cycle after; `busy` high throughout.
- `dir_ini`=`dir_fin`=15: expect a single beat (15,0x400000) with `out_last`=1 and exactly one `reg_rd` cycle.
- `dir_ini`=30, `dir_fin`=1: expect four beats with addresses 30,31,0,1 and data 0,0,0,0.
- `dir_ini`=4, `dir_fin`=5 with `out_ready` low for 5 cycles on the first beat: `out_data` holds 18, `reg_rd` stays 0, then beat 5 follows with no skip or duplicate.
- `rst` pulsed during ESPERA of a 0..31 dump: all outputs read 0 asynchronously; a new `start` with `dir_ini`=10, `dir_fin`=10 yields (10,7).
- With `VOLCADO_CHECKSUM_EN`, `dir_ini`=4, `dir_fin`=5: beats (4,18), (5,7, `out_last`=0), then (0,25, `out_last`=1).
